// File: rtl/dotprod_pkg.sv
// dotprod_pkg: definitions shared by the dot-product loader, operand memory
// bank and compute stage.
//   - DEFAULT_DEPTH / DEFAULT_ADDR_W / DEFAULT_DATA_W: default sizes
//   - state_t: one-hot 4-bit FSM encoding (S_HDR, S_A, S_B, S_DONE), in the
//     same style as the compute stage's states
package dotprod_pkg;

    localparam int DEFAULT_DEPTH  = 256;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [3:0] {
        S_HDR  = 4'b0001,
        S_A    = 4'b0010,
        S_B    = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

endpackage

// File: rtl/dotprod_opmem.sv
// dotprod_opmem: operand memory bank for the dot-product datapath. It holds
// two DEPTH-entry memories (a and b). Writes share a single port and are
// steered by wr_sel. Reads are asynchronous so the compute stage can address
// both banks at once.
// Ports:
//   sys_clk            write clock (rising edge)
//   wr_en              write strobe
//   wr_sel             0 = a bank, 1 = b bank
//   wr_addr / wr_data  write address / data
//   rd_addr            read address (shared by both banks)
//   rd_a / rd_b        asynchronous read data of the a / b bank
module dotprod_opmem
    import dotprod_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              sys_clk,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    // Memory contents are not reset; they are only meaningful once a frame
    // has been loaded.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            if (wr_sel) begin
                mem_b[wr_addr] <= wr_data;
            end else begin
                mem_a[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_a = mem_a[rd_addr];
    assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/dotprod_loader.sv
// dotprod_loader: upstream feeder for the dot-product datapath. It accepts a
// framed valid/ready word stream made of a header word (n), then n a-words,
// then n b-words. It issues registered write strobes into the a/b operand
// memories. When the frame is complete it raises loaded, and holds it until
// the compute stage returns loaded_ack.
// Ports:
//   sys_clk, sys_rst_n   clock and asynchronous active-low reset
//   in_valid/in_ready    stream handshake; in_data is the header or operand word
//   wr_en/wr_sel/wr_addr/wr_data  one-cycle memory write (sel 0 = a, 1 = b)
//   n_out                vector length of the loaded frame
//   loaded/loaded_ack    frame-complete level and its acknowledge
//   len_err              one-cycle pulse for a header with n > DEPTH
//   checksum             running sum of the frame's a and b words
// Optional feature: define DOTPROD_LOADER_CHECKSUM_EN to build the checksum
// accumulator. When it is not defined, checksum is tied to 0.
module dotprod_loader
    import dotprod_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] n_out,
    output logic              loaded,
    input  logic              loaded_ack,
    output logic              len_err,
    output logic [DATA_W-1:0] checksum
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] n_out_q, n_out_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              loaded_q, loaded_d;
    logic              len_err_q, len_err_d;

    logic xfer;
    logic last_elem;

    assign xfer      = in_valid && in_ready_q;
    // n_out holds the accepted length (1..DEPTH) throughout S_A/S_B, so the
    // last-element test never has to deal with n == 0.
    assign last_elem = (DATA_W'(index_q) == (n_out_q - DATA_W'(1)));

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        n_out_d   = n_out_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        len_err_d = 1'b0;

        unique case (state_q)
            S_HDR: begin
                if (xfer) begin
                    if (in_data == '0) begin
                        n_out_d = '0;
                        state_d = S_DONE;
                    end else if (in_data > DATA_W'(DEPTH)) begin
                        // Oversized header is dropped; the previous n_out stays.
                        len_err_d = 1'b1;
                    end else begin
                        n_out_d = in_data;
                        index_d = '0;
                        state_d = S_A;
                    end
                end
            end
            S_A, S_B: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = (state_q == S_B);
                    wr_addr_d = index_q;
                    wr_data_d = in_data;
                    if (last_elem) begin
                        index_d = '0;
                        state_d = (state_q == S_A) ? S_B : S_DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (loaded_ack) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase

        // Registered decodes of the next state. Because loaded rises on the
        // same edge as the last b strobe, both are visible in the same cycle.
        loaded_d   = (state_d == S_DONE);
        in_ready_d = (state_d != S_DONE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_HDR;
            index_q    <= '0;
            n_out_q    <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            loaded_q   <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            n_out_q    <= n_out_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            loaded_q   <= loaded_d;
            len_err_q  <= len_err_d;
        end
    end

`ifdef DOTPROD_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              hdr_accept;
    logic              op_accept;

    // Any header that starts a frame (including n == 0) clears the sum.
    // Operand words are added on the same edge that registers their write,
    // so the sum is complete when loaded rises and then holds.
    assign hdr_accept = xfer && (state_q == S_HDR) && (in_data <= DATA_W'(DEPTH));
    assign op_accept  = xfer && ((state_q == S_A) || (state_q == S_B));

    always_comb begin
        checksum_d = checksum_q;
        if (hdr_accept) begin
            checksum_d = '0;
        end else if (op_accept) begin
            checksum_d = checksum_q + in_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_sel   = wr_sel_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign n_out    = n_out_q;
    assign loaded   = loaded_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_dotprod_loader.sv
// tb_dotprod_loader: self-checking bench for dotprod_loader. Expected writes
// go into a scoreboard queue as operand words are driven, and are popped when
// the loader strobes wr_en. A dotprod_opmem on the write port allows the
// memory contents to be read back. Optional checksum:
// DOTPROD_LOADER_CHECKSUM_EN.
module tb_dotprod_loader;
    import dotprod_pkg::*;

    localparam int DEPTH  = DEFAULT_DEPTH;
    localparam int ADDR_W = DEFAULT_ADDR_W;
    localparam int DATA_W = DEFAULT_DATA_W;

    logic              sys_clk    = 1'b0;
    logic              sys_rst_n  = 1'b0;
    logic              in_valid   = 1'b0;
    logic [DATA_W-1:0] in_data    = '0;
    logic              loaded_ack = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] n_out;
    logic              loaded;
    logic              len_err;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W-1:0] rd_addr    = '0;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    always #5 sys_clk = ~sys_clk;

    dotprod_loader dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .n_out      (n_out),
        .loaded     (loaded),
        .loaded_ack (loaded_ack),
        .len_err    (len_err),
        .checksum   (checksum)
    );

    dotprod_opmem mem (
        .sys_clk (sys_clk),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int push_count   = 0;
    int wr_count     = 0;
    int len_err_count = 0;

    logic [40:0]       sb_q [$];
    logic [40:0]       mon_exp;
    logic [DATA_W-1:0] exp_a [DEPTH];
    logic [DATA_W-1:0] exp_b [DEPTH];
    logic [DATA_W-1:0] frame_sum;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (len_err) len_err_count++;
            if (wr_en) begin
                wr_count++;
                $display("[TB] wr sel=%0d addr=%0d data=0x%08h", wr_sel, wr_addr, wr_data);
                if (sb_q.size() > 0) begin
                    mon_exp = sb_q.pop_front();
                    check("wr_triple", 64'({wr_sel, wr_addr, wr_data}), 64'(mon_exp));
                end
            end
        end
    end

    // Present one word and return at the negedge after it was accepted.
    task automatic send(input logic [DATA_W-1:0] d);
        int waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waits < 50) begin
            @(negedge sys_clk);
            waits++;
        end
        check("ready_wait_bound", 64'(waits < 50), 64'(1));
        @(negedge sys_clk);
    endtask

    task automatic push_wr(input logic sel, input int idx, input logic [DATA_W-1:0] d);
        sb_q.push_back({sel, ADDR_W'(idx), d});
        push_count++;
        if (sel) exp_b[idx] = d;
        else     exp_a[idx] = d;
    endtask

    // Header plus n a-words plus n b-words. Non-random data is a = 1..n and
    // b = n+1..2n. With toggle set, in_valid drops for one cycle after every word.
    task automatic send_frame(input int n, input bit toggle, input bit use_rand);
        logic [DATA_W-1:0] w;
        frame_sum = '0;
        send(DATA_W'(n));
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < n; i++) begin
                w = use_rand ? DATA_W'($urandom) : DATA_W'(s * n + i + 1);
                push_wr(s[0], i, w);
                frame_sum = frame_sum + w;
                send(w);
                if (toggle) begin
                    in_valid = 1'b0;
                    @(negedge sys_clk);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic ack_frame(input string tag);
        loaded_ack = 1'b1;
        @(negedge sys_clk);
        loaded_ack = 1'b0;
        check({tag, "_loaded_cleared"}, 64'(loaded), 64'(0));
        check({tag, "_ready_back"}, 64'(in_ready), 64'(1));
    endtask

    task automatic check_sum(input string tag, input logic [DATA_W-1:0] exp);
`ifdef DOTPROD_LOADER_CHECKSUM_EN
        check(tag, 64'(checksum), 64'(exp));
`else
        check(tag, 64'(checksum), 64'(0) & 64'(exp));
`endif
    endtask

    task automatic readback(input string tag, input int idx);
        rd_addr = ADDR_W'(idx);
        #1;
        check({tag, "_mem_a"}, 64'(rd_a), 64'(exp_a[idx]));
        check({tag, "_mem_b"}, 64'(rd_b), 64'(exp_b[idx]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_wr_en"},    64'(wr_en),    64'(0));
        check({tag, "_wr_sel"},   64'(wr_sel),   64'(0));
        check({tag, "_wr_addr"},  64'(wr_addr),  64'(0));
        check({tag, "_wr_data"},  64'(wr_data),  64'(0));
        check({tag, "_n_out"},    64'(n_out),    64'(0));
        check({tag, "_loaded"},   64'(loaded),   64'(0));
        check({tag, "_len_err"},  64'(len_err),  64'(0));
        check({tag, "_checksum"}, 64'(checksum), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int wr_before;

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // n = 0: no writes, loaded shortly after the header, n_out = 0
        send(DATA_W'(0));
        in_valid = 1'b0;
        waits = 0;
        while (!loaded && waits < 2) begin
            @(negedge sys_clk);
            waits++;
        end
        check("n0_loaded", 64'(loaded), 64'(1));
        check("n0_n_out", 64'(n_out), 64'(0));
        check("n0_no_writes", 64'(wr_count), 64'(0));
        ack_frame("n0");

        // n = 3, continuous valid
        send_frame(3, 1'b0, 1'b0);
        check("n3_last_wr_en", 64'(wr_en), 64'(1));
        check("n3_loaded_with_last", 64'(loaded), 64'(1));
        check("n3_n_out", 64'(n_out), 64'(3));
        check_sum("n3_checksum", DATA_W'(21));
        ack_frame("n3");
        for (int i = 0; i < 3; i++) readback("n3", i);
        check("n3_wr_count", 64'(wr_count), 64'(push_count));

        // n = 257: len_err pulse, header dropped, n_out kept
        send(DATA_W'(257));
        in_valid = 1'b0;
        check("n257_len_err", 64'(len_err), 64'(1));
        check("n257_n_out_kept", 64'(n_out), 64'(3));
        check("n257_still_hdr", 64'(in_ready), 64'(1));
        @(negedge sys_clk);
        check("n257_len_err_pulse", 64'(len_err), 64'(0));
        check("n257_pulse_count", 64'(len_err_count), 64'(1));

        // n = DEPTH, random data
        send_frame(DEPTH, 1'b0, 1'b1);
        check("n256_loaded", 64'(loaded), 64'(1));
        check("n256_n_out", 64'(n_out), 64'(DEPTH));
        check("n256_last_addr", 64'(wr_addr), 64'(DEPTH - 1));
        check_sum("n256_checksum", frame_sum);
        ack_frame("n256");
        readback("n256_first", 0);
        readback("n256_mid", 128);
        readback("n256_last", DEPTH - 1);
        check("n256_wr_count", 64'(wr_count), 64'(push_count));

        // n = 4 with in_valid toggling
        wr_before = wr_count;
        send_frame(4, 1'b1, 1'b0);
        check("toggle_write_count", 64'(wr_count - wr_before), 64'(8));
        check("toggle_loaded", 64'(loaded), 64'(1));
        ack_frame("toggle");
        check("toggle_sb_empty", 64'(sb_q.size()), 64'(0));

        // Reset after two a-words of an n = 5 frame
        send(DATA_W'(5));
        push_wr(1'b0, 0, DATA_W'(32'h11));
        send(DATA_W'(32'h11));
        push_wr(1'b0, 1, DATA_W'(32'h22));
        send(DATA_W'(32'h22));
        #2;
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        #1;
        check_all_zero("midrst");
        sb_q.delete();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        send_frame(2, 1'b0, 1'b1);
        check("post_rst_loaded", 64'(loaded), 64'(1));
        check("post_rst_n_out", 64'(n_out), 64'(2));
        check_sum("post_rst_checksum", frame_sum);

        // loaded held without ack: stream is stalled
        in_valid = 1'b1;
        in_data  = DATA_W'(32'hDEAD);
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            check("hold_ready_low", 64'(in_ready), 64'(0));
            check("hold_loaded", 64'(loaded), 64'(1));
        end
        in_valid = 1'b0;
        ack_frame("hold");
        readback("post_rst", 0);
        readback("post_rst", 1);

        // One-element frame: proves the stalled word was never taken
        send_frame(1, 1'b0, 1'b0);
        check("n1_loaded", 64'(loaded), 64'(1));
        check("n1_n_out", 64'(n_out), 64'(1));
        ack_frame("n1");
        check("final_sb_empty", 64'(sb_q.size()), 64'(0));
        check("final_len_err_count", 64'(len_err_count), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
